nios2_system_pio_scroll_dbuf: RTL and testbench

//  Avalon-MM slave PIO for scroll registers. Holds NUM_CH output channels of DATA_W bits each.

---
 rtl/nios2_system_pio_scroll_dbuf.sv | 98 +++++++++
 tb/tb_nios2_system_pio_scroll_dbuf.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_system_pio_scroll_dbuf.sv
// nios2_system_pio_scroll_dbuf: Avalon-MM PIO with double-buffered scroll channels committed on the vsync rising edge
// Ports: clk, reset_n (async, active-low); address/chipselect/write_n/writedata/readdata (Avalon slave, read latency 0);
//        vsync_in (async frame sync); out_port (active channels); commit_pulse (cycle after load); irq (DONE & IRQ_EN, registered)
module nios2_system_pio_scroll_dbuf #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic                     vsync_in,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     commit_pulse,
  output logic                     irq
);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_CH + 1);
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     r_s_d;
  logic                     r_pending;
  logic                     r_imm;
  logic                     r_irq_en;
  logic                     r_done;
  logic [7:0]               r_frame_cnt;
  logic                     r_commit_pulse;
  logic                     r_irq;
  logic [NUM_CH*DATA_W-1:0] w_sh_flat;
  logic                     w_wr;
  logic                     w_edge;
  logic                     w_commit;
  logic                     w_arm;
  logic                     w_clr;
  logic                     w_unused;
  assign w_wr     = chipselect & ~write_n;
  assign w_edge   = r_sync[SYNC_STAGES-1] & ~r_s_d;
  assign w_commit = w_edge & r_pending & ~r_imm;
  assign w_arm    = w_wr && address == A_CTRL && writedata[0];
  assign w_clr    = w_wr && address == A_STAT && writedata[1];
  assign w_unused = &{1'b0, writedata};
  assign commit_pulse = r_commit_pulse;
  assign irq = r_irq;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync         <= '0;
      r_s_d          <= 1'b0;
      r_pending      <= 1'b0;
      r_imm          <= 1'b0;
      r_irq_en       <= 1'b0;
      r_done         <= 1'b0;
      r_frame_cnt    <= 8'd0;
      r_commit_pulse <= 1'b0;
      r_irq          <= 1'b0;
    end else begin
      r_sync         <= {r_sync[SYNC_STAGES-2:0], vsync_in};
      r_s_d          <= r_sync[SYNC_STAGES-1];
      r_frame_cnt    <= w_edge ? r_frame_cnt + 8'd1 : r_frame_cnt;
      r_pending      <= w_arm ? 1'b1 : (w_commit ? 1'b0 : r_pending);
      r_done         <= w_commit ? 1'b1 : (w_clr ? 1'b0 : r_done);
      r_commit_pulse <= w_commit;
      r_irq          <= r_done & r_irq_en;
      if (w_wr && address == A_CTRL) begin
        r_imm    <= writedata[1];
        r_irq_en <= writedata[2];
      end
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] r_sh;
    logic [DATA_W-1:0] r_act;
    logic              w_sh_wr;
    assign w_sh_wr = w_wr && address == ADDR_W'(c);
    assign w_sh_flat[c*DATA_W +: DATA_W] = r_sh;
    assign out_port[c*DATA_W +: DATA_W] = r_act;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sh  <= RESET_VALUE;
        r_act <= RESET_VALUE;
      end else begin
        r_sh  <= w_sh_wr ? writedata[DATA_W-1:0] : r_sh;
        r_act <= w_commit ? r_sh : ((w_sh_wr && r_imm) ? writedata[DATA_W-1:0] : r_act);
      end
    end
  end
  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (address == ADDR_W'(i)) readdata = 32'(w_sh_flat[i*DATA_W +: DATA_W]);
    if (address == A_CTRL) readdata = {29'b0, r_irq_en, r_imm, r_pending};
    if (address == A_STAT) readdata = {16'b0, r_frame_cnt, 6'b0, r_done, r_pending};
  end
endmodule

// File: tb/tb_nios2_system_pio_scroll_dbuf.sv
// tb_nios2_system_pio_scroll_dbuf: scoreboard bench for the double-buffered scroll PIO
module tb_nios2_system_pio_scroll_dbuf;
  localparam int NUM_CH = 2;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int SYNC_STAGES = 2;
  localparam int OW = NUM_CH * DATA_W;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic vsync_in = 1'b0;
  logic chk_out = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [OW-1:0] out_port;
  logic commit_pulse;
  logic irq;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {int cy; logic [OW-1:0] o;} cp_t;
  typedef struct {logic [ADDR_W-1:0] a; logic [31:0] v;} rd_t;
  typedef struct {logic [OW-1:0] o; logic irq;} ob_t;
  cp_t cp_q[$];
  rd_t rd_q[$];
  ob_t out_q[$];
  cp_t me;
  rd_t mr;
  ob_t mo;
  logic [DATA_W-1:0] m_sh[NUM_CH];
  logic [DATA_W-1:0] m_act[NUM_CH];
  logic m_pend, m_imm, m_irq_en, m_done;
  logic [7:0] m_fc;
  logic [7:0] fc_start;
  nios2_system_pio_scroll_dbuf #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(8'h00)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .vsync_in(vsync_in), .out_port(out_port),
    .commit_pulse(commit_pulse), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (chipselect && write_n) begin
      if (rd_q.size() == 0) check("read_unexpected", 64'd1, 64'd0);
      else begin
        mr = rd_q.pop_front();
        check($sformatf("read_addr%0d", mr.a), 64'(readdata), 64'(mr.v));
      end
    end
    if (commit_pulse) begin
      if (cp_q.size() == 0) check("commit_pulse_unexpected", 64'd1, 64'd0);
      else begin
        me = cp_q.pop_front();
        check("commit_cycle", 64'(cyc), 64'(me.cy));
        check("commit_out_port", 64'(out_port), 64'(me.o));
      end
    end
    if (chk_out) begin
      if (out_q.size() == 0) check("out_check_unexpected", 64'd1, 64'd0);
      else begin
        mo = out_q.pop_front();
        check("out_port", 64'(out_port), 64'(mo.o));
        check("irq", 64'(irq), 64'(mo.irq));
        check("commit_pulse_idle", 64'(commit_pulse), 64'd0);
      end
    end
  end
  function automatic void m_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_sh[i] = '0;
      m_act[i] = '0;
    end
    m_pend = 0; m_imm = 0; m_irq_en = 0; m_done = 0; m_fc = 0;
  endfunction
  function automatic logic [OW-1:0] m_out();
    logic [OW-1:0] o;
    for (int i = 0; i < NUM_CH; i++) o[i*DATA_W +: DATA_W] = m_act[i];
    return o;
  endfunction
  function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
    if (int'(a) < NUM_CH) return 32'(m_sh[a]);
    if (int'(a) == NUM_CH) return {29'b0, m_irq_en, m_imm, m_pend};
    if (int'(a) == NUM_CH + 1) return {16'b0, m_fc, 6'b0, m_done, m_pend};
    return 32'd0;
  endfunction
  function automatic void m_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    if (int'(a) < NUM_CH) begin
      m_sh[a] = d[DATA_W-1:0];
      if (m_imm) m_act[a] = d[DATA_W-1:0];
    end else if (int'(a) == NUM_CH) begin
      if (d[0]) m_pend = 1;
      m_imm = d[1];
      m_irq_en = d[2];
    end else if (int'(a) == NUM_CH + 1) begin
      if (d[1]) m_done = 0;
    end
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 0; write_n = 1;
    m_write(a, d);
  endtask
  task automatic rd(input logic [ADDR_W-1:0] a);
    rd_t t;
    t.a = a;
    t.v = m_read(a);
    rd_q.push_back(t);
    chipselect = 1; write_n = 1; address = a;
    @(posedge clk);
    #1;
    chipselect = 0;
  endtask
  task automatic chk();
    ob_t t;
    idle(1);
    t.o = m_out();
    t.irq = m_done & m_irq_en;
    out_q.push_back(t);
    chk_out = 1;
    @(posedge clk);
    #1;
    chk_out = 0;
  endtask
  // One vsync pulse; optionally a bus write lands on the same clk edge as the commit.
  task automatic vs(input bit dw, input logic [ADDR_W-1:0] a, input logic [31:0] d, input int hold);
    bit c;
    cp_t t;
    vsync_in = 1;
    idle(SYNC_STAGES);
    if (dw) begin
      chipselect = 1; write_n = 0; address = a; writedata = d;
    end
    c = m_pend && !m_imm;
    @(posedge clk);
    #1;
    chipselect = 0; write_n = 1;
    m_fc = m_fc + 8'd1;
    if (c) begin
      for (int i = 0; i < NUM_CH; i++) m_act[i] = m_sh[i];
      m_pend = 0;
    end
    if (dw) m_write(a, d);
    if (c) begin
      m_done = 1;
      t.cy = cyc;
      t.o = m_out();
      cp_q.push_back(t);
    end
    idle(hold);
    vsync_in = 0;
    idle(SYNC_STAGES + 2);
  endtask
  initial begin
    m_reset();
    idle(3);
    reset_n = 1;
    idle(1);
    for (int a = 0; a < 8; a++) rd(3'(a));
    chk();
    wr(0, 32'h12);
    wr(1, 32'h34);
    vs(0, 0, 0, 1);
    chk();
    rd(3);
    rd(0);
    wr(2, 32'h5);
    vs(0, 0, 0, 2);
    chk();
    rd(2);
    rd(3);
    wr(3, 32'h2);
    chk();
    wr(2, 32'h5);
    vs(1, 0, 32'h55, 1);
    chk();
    rd(0);
    wr(2, 32'h5);
    vs(1, 2, 32'h5, 1);
    rd(2);
    vs(1, 3, 32'h2, 1);
    rd(3);
    chk();
    wr(2, 32'h3);
    wr(1, 32'hAA);
    chk();
    vs(0, 0, 0, 1);
    rd(2);
    chk();
    wr(2, 32'h0);
    vs(0, 0, 0, 1);
    chk();
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: wr(3'($urandom_range(0, NUM_CH - 1)), $urandom);
        3: wr(3'(NUM_CH), {29'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))});
        4: wr(3'(NUM_CH + 1), {30'b0, 1'($urandom_range(0, 1)), 1'b0});
        5, 6: rd(3'($urandom_range(0, 7)));
        7: vs(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom & 32'h7 | ($urandom & 32'hF8), $urandom_range(0, 3));
        8: chk();
        default: wr(3'($urandom_range(NUM_CH + 2, 7)), $urandom);
      endcase
    end
    wr(2, 32'h0);
    fc_start = m_fc;
    repeat (256) vs(0, 0, 0, 0);
    rd(3);
    wr(0, 32'hC3);
    wr(1, 32'h3C);
    wr(2, 32'h5);
    vs(0, 0, 0, 1);
    wr(2, 32'h5);
    chk();
    vsync_in = 1;
    idle(1);
    #2;
    reset_n = 0;
    m_reset();
    mo.o = m_out();
    mo.irq = 0;
    out_q.push_back(mo);
    chk_out = 1;
    @(posedge clk);
    #1;
    chk_out = 0;
    idle(1);
    reset_n = 1;
    idle(SYNC_STAGES + 3);
    m_fc = 8'd1;
    vsync_in = 0;
    idle(SYNC_STAGES + 2);
    rd(3);
    rd(2);
    rd(0);
    rd(1);
    chk();
    idle(5);
    check("commit_queue_drained", 64'(cp_q.size()), 64'd0);
    check("read_queue_drained", 64'(rd_q.size()), 64'd0);
    check("out_queue_drained", 64'(out_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
